// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS fetch program counter with next-PC select, sticky halt, alignment flag and saturating update counter.
// Define PC_RAS_EN to add a circular return-address stack for return prediction.
module pc_sequencer #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter int          CNT_W     = 32,
    parameter int          RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             pcWEN,
    input  logic [1:0]       pc_sel,
    input  logic [15:0]      imm16,
    input  logic [25:0]      jaddr,
    input  logic [WIDTH-1:0] reg_addr,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt,
    input  logic             is_call,
    input  logic             is_ret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] upd_count,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_valid
);
    logic [WIDTH-1:0] pc_q, pc_d, br_off, br_pc, jmp_pc, raw;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d, mis_q, mis_d, accept;

    assign pc_plus4 = pc_q + WIDTH'(4);
    assign br_off   = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
    assign br_pc    = pc_plus4 + br_off;
    assign jmp_pc   = {pc_plus4[WIDTH-1:28], jaddr, 2'b00};
    assign raw      = redirect        ? redirect_pc :
                      pc_sel == 2'b00 ? pc_plus4    :
                      pc_sel == 2'b01 ? br_pc       :
                      pc_sel == 2'b10 ? jmp_pc      : reg_addr;
    // A halted sequencer accepts nothing, not even a redirect.
    assign accept   = !halted_q && (redirect || pcWEN);

    always_comb begin
        pc_d     = accept ? {raw[WIDTH-1:2], 2'b00} : pc_q;
        mis_d    = halted_q ? mis_q : (accept && raw[1:0] != 2'b00);
        cnt_d    = (accept && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        halted_d = halted_q || halt;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q     <= WIDTH'(PC_INIT);
            cnt_q    <= '0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
        end
    end

    assign pc_out       = pc_q;
    assign halted       = halted_q;
    assign misalign_err = mis_q;
    assign upd_count    = cnt_q;

`ifdef PC_RAS_EN
    localparam int AW = $clog2(RAS_DEPTH);
    logic [WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [AW-1:0]    tp_q, tp_d, tp_pop;
    logic [AW:0]      rcnt_q, rcnt_d, rcnt_pop;
    logic             ras_acc, push, pop;

    assign ras_acc  = !halted_q && !redirect && pcWEN;
    assign pop      = ras_acc && is_ret && rcnt_q != '0;
    assign push     = ras_acc && is_call;
    // Pop is applied first so call+ret together replaces the top entry.
    assign tp_pop   = pop ? tp_q - AW'(1) : tp_q;
    assign rcnt_pop = pop ? rcnt_q - (AW+1)'(1) : rcnt_q;

    always_comb begin
        tp_d   = push ? tp_pop + AW'(1) : tp_pop;
        rcnt_d = (push && rcnt_pop != (AW+1)'(RAS_DEPTH)) ? rcnt_pop + (AW+1)'(1) : rcnt_pop;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tp_q   <= '0;
            rcnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            tp_q   <= tp_d;
            rcnt_q <= rcnt_d;
            if (push) stack_q[tp_d] <= pc_plus4;
        end
    end

    assign ras_valid = rcnt_q != '0;
    assign ras_top   = ras_valid ? stack_q[tp_q] : '0;
`else
    logic unused_ras;
    assign unused_ras = ^{is_call, is_ret};
    assign ras_valid  = 1'b0;
    assign ras_top    = '0;
`endif
endmodule
